// File: rtl/rs_issue_queue.sv
// rs_issue_queue: reservation-station issue queue.
// Dispatched uops wait for their source tags to be woken up. One ready uop
// per cycle is issued toward register read, oldest first, chosen through an
// age matrix.
module rs_issue_queue #(
  parameter int RS_ENTRIES = 8,
  parameter int NUM_PREGS  = 128,
  parameter int NUM_WAKEUP = 2,
  parameter int OPC_W      = 6,
  localparam int PREG_W    = $clog2(NUM_PREGS),
  localparam int CNT_W     = $clog2(RS_ENTRIES) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [PREG_W-1:0]            disp_src1_index,
  input  logic [PREG_W-1:0]            disp_src2_index,
  input  logic                         disp_src1_rdy,
  input  logic                         disp_src2_rdy,
  input  logic [PREG_W-1:0]            disp_dst_index,
  input  logic [31:0]                  disp_imm_val,
  input  logic [OPC_W-1:0]             disp_opcode,
  input  logic [NUM_WAKEUP-1:0]        wk_valid,
  input  logic [NUM_WAKEUP*PREG_W-1:0] wk_tag,
  output logic                         sel_valid,
  input  logic                         sel_ready,
  output logic [PREG_W-1:0]            sel_src1_index,
  output logic [PREG_W-1:0]            sel_src2_index,
  output logic [PREG_W-1:0]            sel_dst_index,
  output logic [31:0]                  sel_imm_val,
  output logic [OPC_W-1:0]             sel_opcode,
  output logic [CNT_W-1:0]             occupancy
);

  logic [RS_ENTRIES-1:0] r_valid;
  logic [RS_ENTRIES-1:0] r_s1rdy;
  logic [RS_ENTRIES-1:0] r_s2rdy;
  logic [PREG_W-1:0]     r_src1 [RS_ENTRIES];
  logic [PREG_W-1:0]     r_src2 [RS_ENTRIES];
  logic [PREG_W-1:0]     r_dst  [RS_ENTRIES];
  logic [31:0]           r_imm  [RS_ENTRIES];
  logic [OPC_W-1:0]      r_opc  [RS_ENTRIES];
  // r_older[j][i] = 1 means entry j was written before entry i
  logic [RS_ENTRIES-1:0] r_older [RS_ENTRIES];
  logic [CNT_W-1:0]      r_occ;

  logic [RS_ENTRIES-1:0] w_wk1, w_wk2;
  logic                  w_dwk1, w_dwk2;
  logic [RS_ENTRIES-1:0] w_req, w_blocked, w_grant, w_free_oh;
  logic                  w_accept, w_issue;

  // Tag compare of every wakeup port against stored and dispatching sources
  always_comb begin
    w_wk1  = '0;
    w_wk2  = '0;
    w_dwk1 = 1'b0;
    w_dwk2 = 1'b0;
    for (int unsigned p = 0; p < NUM_WAKEUP; p++) begin
      if (wk_valid[p]) begin
        if (wk_tag[p*PREG_W +: PREG_W] == disp_src1_index) w_dwk1 = 1'b1;
        if (wk_tag[p*PREG_W +: PREG_W] == disp_src2_index) w_dwk2 = 1'b1;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
          if (wk_tag[p*PREG_W +: PREG_W] == r_src1[i]) w_wk1[i] = 1'b1;
          if (wk_tag[p*PREG_W +: PREG_W] == r_src2[i]) w_wk2[i] = 1'b1;
        end
      end
    end
  end

  // Oldest-first select among requestable entries, lowest free slot finder
  always_comb begin
    w_req     = r_valid & r_s1rdy & r_s2rdy;
    w_blocked = '0;
    w_free_oh = '0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
        if (w_req[j] && r_older[j][i]) w_blocked[i] = 1'b1;
      end
    end
    w_grant = w_req & ~w_blocked;
    for (int unsigned i = RS_ENTRIES; i > 0; i--) begin
      if (!r_valid[i-1]) w_free_oh = RS_ENTRIES'(1) << (i-1);
    end
  end

  assign disp_ready = (r_occ != CNT_W'(RS_ENTRIES));
  assign sel_valid  = |w_req;
  assign w_accept   = disp_valid & disp_ready;
  assign w_issue    = sel_valid & sel_ready;
  assign occupancy  = r_occ;

  // One-hot grant mux; all-zero data when nothing is granted
  always_comb begin
    sel_src1_index = '0;
    sel_src2_index = '0;
    sel_dst_index  = '0;
    sel_imm_val    = '0;
    sel_opcode     = '0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      sel_src1_index = sel_src1_index | ({PREG_W{w_grant[i]}} & r_src1[i]);
      sel_src2_index = sel_src2_index | ({PREG_W{w_grant[i]}} & r_src2[i]);
      sel_dst_index  = sel_dst_index  | ({PREG_W{w_grant[i]}} & r_dst[i]);
      sel_imm_val    = sel_imm_val    | ({32{w_grant[i]}} & r_imm[i]);
      sel_opcode     = sel_opcode     | ({OPC_W{w_grant[i]}} & r_opc[i]);
    end
  end

  // Entry state, age matrix and occupancy; flush overrides all updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_s1rdy <= '0;
      r_s2rdy <= '0;
      r_occ   <= '0;
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
        r_src1[i]  <= '0;
        r_src2[i]  <= '0;
        r_dst[i]   <= '0;
        r_imm[i]   <= '0;
        r_opc[i]   <= '0;
        r_older[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int unsigned i = 0; i < RS_ENTRIES; i++) r_older[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
        if (r_valid[i] && w_wk1[i]) r_s1rdy[i] <= 1'b1;
        if (r_valid[i] && w_wk2[i]) r_s2rdy[i] <= 1'b1;
        // The free slot is never valid, so its write cannot collide with wakeup
        if (w_accept && w_free_oh[i]) begin
          r_s1rdy[i] <= disp_src1_rdy | w_dwk1;
          r_s2rdy[i] <= disp_src2_rdy | w_dwk2;
          r_src1[i]  <= disp_src1_index;
          r_src2[i]  <= disp_src2_index;
          r_dst[i]   <= disp_dst_index;
          r_imm[i]   <= disp_imm_val;
          r_opc[i]   <= disp_opcode;
          r_older[i] <= '0;
          for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
            if (j != i) r_older[j][i] <= r_valid[j];
          end
        end
      end
      r_valid <= (r_valid & ~(w_issue ? w_grant : '0)) | (w_accept ? w_free_oh : '0);
      r_occ   <= r_occ + CNT_W'(w_accept) - CNT_W'(w_issue);
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue with hand-computed expectations.
module tb_rs_issue_queue;

  localparam int PW = 7;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          disp_valid;
  logic          disp_ready;
  logic [PW-1:0] disp_src1_index, disp_src2_index, disp_dst_index;
  logic          disp_src1_rdy, disp_src2_rdy;
  logic [31:0]   disp_imm_val;
  logic [OW-1:0] disp_opcode;
  logic [1:0]    wk_valid;
  logic [2*PW-1:0] wk_tag;
  logic          sel_valid, sel_ready;
  logic [PW-1:0] sel_src1_index, sel_src2_index, sel_dst_index;
  logic [31:0]   sel_imm_val;
  logic [OW-1:0] sel_opcode;
  logic [3:0]    occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs_issue_queue #(.RS_ENTRIES(8), .NUM_PREGS(128), .NUM_WAKEUP(2), .OPC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1_index(disp_src1_index), .disp_src2_index(disp_src2_index),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_index(disp_dst_index), .disp_imm_val(disp_imm_val),
    .disp_opcode(disp_opcode), .wk_valid(wk_valid), .wk_tag(wk_tag),
    .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_src1_index(sel_src1_index), .sel_src2_index(sel_src2_index),
    .sel_dst_index(sel_dst_index), .sel_imm_val(sel_imm_val),
    .sel_opcode(sel_opcode), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic disp(input int s1, input logic r1, input int s2, input logic r2,
                      input int dst, input int imm, input int opc);
    disp_valid      = 1'b1;
    disp_src1_index = PW'(s1);
    disp_src1_rdy   = r1;
    disp_src2_index = PW'(s2);
    disp_src2_rdy   = r2;
    disp_dst_index  = PW'(dst);
    disp_imm_val    = imm;
    disp_opcode     = OW'(opc);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; sel_ready = 1'b0;
    disp_src1_index = '0; disp_src2_index = '0; disp_dst_index = '0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_imm_val = '0; disp_opcode = '0;
    wk_valid = '0; wk_tag = '0;

    // reset state
    #3;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_dready", 32'(disp_ready), 1);
    chk("rst_svalid", 32'(sel_valid), 0);
    chk("rst_sdst", 32'(sel_dst_index), 0);
    chk("rst_simm", sel_imm_val, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // single uop: dispatch -> visible next cycle -> issued
    cyc();
    disp(5, 1, 6, 1, 7, 32'h10, 3); sel_ready = 1'b1;
    settle();
    chk("t1_sv_dispcyc", 32'(sel_valid), 0);
    cyc();
    disp_valid = 1'b0;
    settle();
    chk("t1_sv", 32'(sel_valid), 1);
    chk("t1_src1", 32'(sel_src1_index), 5);
    chk("t1_src2", 32'(sel_src2_index), 6);
    chk("t1_dst", 32'(sel_dst_index), 7);
    chk("t1_imm", sel_imm_val, 32'h10);
    chk("t1_opc", 32'(sel_opcode), 3);
    chk("t1_occ1", 32'(occupancy), 1);
    cyc(); settle();
    chk("t1_occ0", 32'(occupancy), 0);
    chk("t1_sv0", 32'(sel_valid), 0);
    chk("t1_imm0", sel_imm_val, 0);

    // younger ready uop bypasses older waiting uop; wakeup releases the older one
    cyc();
    disp(1, 1, 9, 0, 10, 32'hA, 1);
    cyc();
    disp(2, 1, 3, 1, 11, 32'hB, 2);
    settle();
    chk("t2_sv_none", 32'(sel_valid), 0);
    cyc();
    disp_valid = 1'b0;
    wk_valid = 2'b01; wk_tag = {7'd0, 7'd9};
    settle();
    chk("t2_first_dst", 32'(sel_dst_index), 11);
    chk("t2_occ2", 32'(occupancy), 2);
    cyc();
    wk_valid = 2'b00;
    settle();
    chk("t2_second_sv", 32'(sel_valid), 1);
    chk("t2_second_dst", 32'(sel_dst_index), 10);
    chk("t2_occ1", 32'(occupancy), 1);
    cyc(); settle();
    chk("t2_occ0", 32'(occupancy), 0);

    // dispatch-cycle wakeup bypass, and an invalid broadcast that must not wake
    cyc();
    sel_ready = 1'b0;
    disp(20, 0, 21, 1, 22, 32'h20, 4);
    wk_valid = 2'b10; wk_tag = {7'd20, 7'd0};
    settle();
    chk("t3_sv_dispcyc", 32'(sel_valid), 0);
    cyc();
    disp(30, 0, 31, 1, 32, 32'h30, 5);
    wk_valid = 2'b00; wk_tag = {7'd30, 7'd30};
    settle();
    chk("t3_byp_sv", 32'(sel_valid), 1);
    chk("t3_byp_src1", 32'(sel_src1_index), 20);
    cyc();
    disp_valid = 1'b0; sel_ready = 1'b1;
    settle();
    chk("t3_x_dst", 32'(sel_dst_index), 22);
    chk("t3_occ2", 32'(occupancy), 2);
    cyc();
    wk_valid = 2'b01; wk_tag = {7'd0, 7'd30};
    settle();
    chk("t3_nowake_sv", 32'(sel_valid), 0);
    chk("t3_occ1", 32'(occupancy), 1);
    cyc();
    wk_valid = 2'b00;
    settle();
    chk("t3_y_dst", 32'(sel_dst_index), 32);
    cyc(); settle();
    chk("t3_occ0", 32'(occupancy), 0);

    // fill all 8 entries, then drain in dispatch order
    sel_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      disp(40 + i, 1, 50 + i, 1, 60 + i, 32'h100 + i, i);
    end
    cyc();
    disp(99, 1, 99, 1, 99, 32'h999, 9);
    settle();
    chk("t4_full_occ", 32'(occupancy), 8);
    chk("t4_full_dready", 32'(disp_ready), 0);
    chk("t4_head_dst", 32'(sel_dst_index), 60);
    for (int k = 0; k < 8; k++) begin
      cyc();
      disp_valid = 1'b0; sel_ready = 1'b1;
      settle();
      chk($sformatf("t4_drain_dst%0d", k), 32'(sel_dst_index), 32'(60 + k));
      chk($sformatf("t4_drain_imm%0d", k), sel_imm_val, 32'h100 + k);
      chk($sformatf("t4_drain_occ%0d", k), 32'(occupancy), 32'(8 - k));
      chk($sformatf("t4_drain_drdy%0d", k), 32'(disp_ready), (k == 0) ? 32'd0 : 32'd1);
    end
    cyc(); settle();
    chk("t4_empty_occ", 32'(occupancy), 0);
    chk("t4_empty_sv", 32'(sel_valid), 0);

    // full queue with simultaneous accept+issue, then flush with dispatch pending
    sel_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      disp(40 + i, 1, 50 + i, 1, 70 + i, 32'h200 + i, 1);
    end
    cyc();
    disp(1, 1, 1, 1, 80, 32'h80, 1); sel_ready = 1'b1;
    settle();
    chk("t5_full_dready", 32'(disp_ready), 0);
    chk("t5_issue_dst", 32'(sel_dst_index), 70);
    cyc();
    disp(1, 1, 1, 1, 81, 32'h81, 1);
    settle();
    chk("t5_occ7a", 32'(occupancy), 7);
    chk("t5_dready", 32'(disp_ready), 1);
    chk("t5_issue2_dst", 32'(sel_dst_index), 71);
    cyc();
    disp_valid = 1'b0; sel_ready = 1'b0;
    settle();
    chk("t5_occ7b", 32'(occupancy), 7);
    chk("t5_next_dst", 32'(sel_dst_index), 72);
    cyc();
    flush = 1'b1; sel_ready = 1'b1;
    disp(2, 1, 2, 1, 90, 32'h90, 1);
    settle();
    chk("t5_flush_sv_pre", 32'(sel_valid), 1);
    cyc();
    flush = 1'b0; disp_valid = 1'b0;
    settle();
    chk("t5_flush_occ", 32'(occupancy), 0);
    chk("t5_flush_sv", 32'(sel_valid), 0);
    cyc(); settle();
    chk("t5_post_sv", 32'(sel_valid), 0);
    chk("t5_post_occ", 32'(occupancy), 0);

    // asynchronous reset between edges with 3 valid entries
    sel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      disp(10 + i, 1, 11 + i, 1, 12 + i, 32'h300 + i, 2);
    end
    cyc();
    disp_valid = 1'b0;
    settle();
    chk("t6_pre_occ", 32'(occupancy), 3);
    chk("t6_pre_sv", 32'(sel_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sv", 32'(sel_valid), 0);
    chk("t6_rst_occ", 32'(occupancy), 0);
    chk("t6_rst_dready", 32'(disp_ready), 1);
    chk("t6_rst_dst", 32'(sel_dst_index), 0);
    cyc();
    rst_n = 1'b1;
    cyc(); settle();
    chk("t6_after_sv", 32'(sel_valid), 0);
    chk("t6_after_occ", 32'(occupancy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
